// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: drives en/clr of the
// PC and the four stage registers, and counts stall and redirect-flush cycles.
module pipe_ctrl #(
  parameter int unsigned REGW        = 5,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned CNTW        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_redirect,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_clr,
  output logic            idex_en,
  output logic            idex_clr,
  output logic            exmem_en,
  output logic            exmem_clr,
  output logic            memwb_en,
  output logic            memwb_clr,
  output logic            busy,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam int unsigned ICW = $clog2(INIT_CYCLES) + 1;

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;
  typedef enum logic [2:0] {M_INIT, M_FREEZE, M_FLUSH, M_STALL, M_NORMAL} mode_t;

  state_t         state, state_n;
  mode_t          mode;
  logic [ICW-1:0] init_cnt, init_cnt_n;
  logic           hazard;
  logic           stall_inc, flush_inc;

  assign hazard = ex_is_load && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // Pick the active rule and the next state
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    mode       = M_NORMAL;
    case (state)
      INIT: begin
        mode = M_INIT;
        if (init_cnt == '0) state_n = RUN;
        else                init_cnt_n = init_cnt - ICW'(1);
      end
      RUN, MEM_WAIT: begin
        if (!mem_ready && (mem_req || state == MEM_WAIT)) begin
          mode    = M_FREEZE;
          state_n = MEM_WAIT;
        end else begin
          state_n = RUN;
          if (ex_redirect) mode = M_FLUSH;
          else if (hazard) mode = M_STALL;
          else             mode = M_NORMAL;
        end
      end
      default: begin
        mode    = M_INIT;
        state_n = INIT;
      end
    endcase
  end

  // Mealy control decode
  always_comb begin
    {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr} = 9'b1_10_10_10_10;
    case (mode)
      M_INIT:   {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr} = 9'b0_11_11_11_11;
      M_FREEZE: {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr} = 9'b0_00_00_00_11;
      M_FLUSH:  {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr} = 9'b1_11_11_10_10;
      M_STALL:  {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr} = 9'b0_00_11_10_10;
      default:  {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr} = 9'b1_10_10_10_10;
    endcase
  end

  assign busy      = (state == INIT) || (state == MEM_WAIT);
  assign stall_inc = (state != INIT) && !pc_en;
  assign flush_inc = (mode == M_FLUSH);

  // State, init countdown and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= ICW'(INIT_CYCLES - 1);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNTW'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the `en`/`clr` pins of the PC register and the four `rPipe` stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB):
- Inserts a post-reset flush sequence.
- Stalls on load-use hazards.
- Flushes on taken branches and jumps.
- Freezes the pipeline while the data memory is not ready.
- Keeps stall and flush performance counters.

## Interface
- `REGW`, 5, register-index width.
- `INIT_CYCLES`, 4, post-reset flush cycles; must be ≥ 1.
- `CNTW`, 32, performance counter width.

- `clk` in 1, clock; all state changes on the rising edge.
- `rst_n` in 1, reset, asynchronous, active-low.
- `id_rs1`, `id_rs2` in REGW each, source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each, ID instruction actually reads rs1 / rs2.
- `ex_rd` in REGW, destination register of the instruction in EX.
- `ex_is_load` in 1, EX instruction is a load.
- `ex_redirect` in 1, EX resolved a taken branch or jump.
- `mem_req` in 1, MEM stage has an active data-memory access.
- `mem_ready` in 1, data memory completes the access this cycle.
- `pc_en` out 1, PC register enable.
- `ifid_en`, `ifid_clr` out 1 each, IF/ID register controls.
- `idex_en`, `idex_clr` out 1 each, ID/EX register controls.
- `exmem_en`, `exmem_clr` out 1 each, EX/MEM register controls.
- `memwb_en`, `memwb_clr` out 1 each, MEM/WB register controls.
- `busy` out 1, high in INIT or MEM_WAIT.
- `stall_cnt` out CNTW, count of cycles with `pc_en`=0 outside INIT.
- `flush_cnt` out CNTW, count of redirect flushes.

## Operation
Stage-register convention: `clr`=1 clears the register on the next edge regardless of `en`. Otherwise `en`=1 loads and `en`=0 holds.

State machine (registered `state`, plus `init_cnt` of width clog2(INIT_CYCLES)+1):
- **INIT.** Entered on reset with `init_cnt`=INIT_CYCLES-1.
  - Outputs: `pc_en`=0, all `*_en`=1, all `*_clr`=1.
  - `init_cnt` decrements each cycle. At 0, go to RUN.
  - All hazard inputs are ignored.
- **RUN.** Outputs come from the first matching rule, in priority order:
  1. **Memory wait:** `mem_req`=1 and `mem_ready`=0. Freeze, go to MEM_WAIT.
  2. **Redirect:** `ex_redirect`=1. `pc_en`=1, all `en`=1, `ifid_clr`=1, `idex_clr`=1, other `clr`=0. `flush_cnt`++.
  3. **Load-use:** `ex_is_load`=1, `ex_rd`≠0, and (`id_use_rs1` & `id_rs1`==`ex_rd` | `id_use_rs2` & `id_rs2`==`ex_rd`). `pc_en`=0, `ifid_en`=0, `idex_clr`=1, `exmem_en`=`memwb_en`=1, other `clr`=0.
  4. **Normal:** all `en`=1, all `clr`=0, `pc_en`=1.
- **MEM_WAIT.**
  - While `mem_ready`=0, freeze.
  - When `mem_ready`=1, evaluate RUN rules 2–4 in the same cycle and go to RUN.
  - Inputs from frozen stages are stable, so no redirect or hazard is lost.
- **Freeze:** `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0, all hold. `memwb_en`=1 and `memwb_clr`=1, so a bubble is inserted into WB.

Counters:
- `stall_cnt` increments in every RUN or MEM_WAIT cycle with `pc_en`=0.
- Both counters saturate at 2^CNTW-1 and never wrap.

## Timing
- All control outputs are combinational (Mealy) from `state` and the current inputs, and are valid in the same cycle the stage registers sample them.
- `busy` is decoded from `state` only.
- Reset values (asynchronous, immediate while `rst_n`=0):
  - `state`=INIT, `pc_en`=0, all `*_en`=1, all `*_clr`=1.
  - `busy`=1, `stall_cnt`=`flush_cnt`=0.
- Reset asserted mid-operation aborts any state immediately. The full INIT sequence replays after `rst_n` rises.
- INIT lasts exactly INIT_CYCLES rising edges after reset release. The first RUN cycle follows.
- Load-use stall lasts 1 cycle per hazard. On the next cycle the load is in MEM, so the hazard is gone.
- Memory wait of N cycles with `mem_ready`=0 gives N freeze cycles and adds N to `stall_cnt`.
- Redirect costs 2 bubbles (IF/ID and ID/EX cleared) and does not count as a stall.
- Redirect together with load-use in the same cycle: redirect wins, since the ID instruction is discarded anyway.
- Memory wait together with redirect: freeze wins. The redirect is applied in the `mem_ready` cycle.

## Test plan
- **Reset/INIT:** `rst_n`=0 for 3 cycles, then 1 → `pc_en`=0 and all `clr`=1 for exactly 4 edges. Then `pc_en`=1, `busy`=0, counters 0.
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → one cycle with `pc_en`=0, `ifid_en`=0, `idex_clr`=1. `stall_cnt`=1. Repeat with `ex_rd`=0 → no stall.
- **Redirect:** `ex_redirect`=1 for 1 cycle → `ifid_clr`=`idex_clr`=1, `pc_en`=1, `flush_cnt`=1. Assert simultaneously with a load-use match → same result, `stall_cnt` unchanged.
- **Memory wait:** `mem_req`=1 with `mem_ready`=0 for 3 cycles, then 1 → 3 freeze cycles (`memwb_clr`=1, others hold), `busy`=1. Release cycle shows all `en`=1. `stall_cnt`=3.
- **Wait plus redirect:** `ex_redirect`=1 held during a 2-cycle wait → no flush while frozen. Flush occurs in the `mem_ready` cycle. `flush_cnt`=1.
- **Async reset mid-wait:** drop `rst_n` during MEM_WAIT → outputs switch to reset values without a clock edge. Counters 0.
